// File: rtl/pcie_rp_link_seq.sv
// pcie_rp_link_seq: PCIe root-port slot power/PERST#/training sequencer with retry and link-loss handling.
// Revision 1.0
`default_nettype none

module pcie_rp_link_seq #(
   parameter int unsigned PWR_CYC   = 16,
   parameter int unsigned PERST_CYC = 32,
   parameter int unsigned TRAIN_CYC = 1024,
   parameter int unsigned DOWN_CYC  = 4,
   parameter int unsigned MAX_RETRY = 3,
   parameter logic [4:0]  L0_CODE   = 5'h0F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hps_ready,
   input  logic       sw_reset,
   input  logic       refclk_locked,
   input  logic [4:0] ltssm,
   output logic [1:0] w_dis_n,
   output logic       perst_n,
   output logic       npor,
   output logic       link_up,
   output logic       link_fail,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_PWR   = 3'd1,
      S_PERST = 3'd2,
      S_TRAIN = 3'd3,
      S_UP    = 3'd4,
      S_FAIL  = 3'd5
   } state_t;

   localparam logic [23:0] c_PWR_LAST   = 24'(PWR_CYC - 1);
   localparam logic [23:0] c_PERST_LAST = 24'(PERST_CYC - 1);
   localparam logic [23:0] c_TRAIN_LAST = 24'(TRAIN_CYC - 1);
   localparam logic [23:0] c_DOWN_LAST  = 24'(DOWN_CYC - 1);
   localparam logic [1:0]  c_MAX_RETRY  = 2'(MAX_RETRY);

   state_t      r_state;
   logic [23:0] r_cnt;
   logic [23:0] r_down;
   logic [4:0]  r_ltssm_q1;
   logic [4:0]  r_ltssm_q;

   state_t      w_nxt;
   logic [23:0] w_cnt_nxt;
   logic [23:0] w_down_nxt;
   logic [1:0]  w_retry_nxt;
   logic        w_retry;
   logic        w_l0;
   logic        w_abort;

   assign w_l0    = (r_ltssm_q == L0_CODE);
   assign w_abort = sw_reset | ~hps_ready | ~refclk_locked;
   assign state   = r_state;

   always_comb begin
      w_nxt       = r_state;
      w_retry     = 1'b0;
      w_retry_nxt = retry_cnt;
      w_down_nxt  = '0;
      case (r_state)
         S_OFF:   w_nxt = S_PWR;
         S_PWR:   if (r_cnt == c_PWR_LAST) w_nxt = S_PERST;
         S_PERST: if (r_cnt == c_PERST_LAST) w_nxt = S_TRAIN;
         S_TRAIN: begin
            // L0 is checked first so it wins over a coincident timeout
            if (w_l0)
               w_nxt = S_UP;
            else if (r_cnt == c_TRAIN_LAST)
               w_retry = 1'b1;
         end
         S_UP: begin
            if (!w_l0) begin
               if (r_down == c_DOWN_LAST)
                  w_retry = 1'b1;
               else
                  w_down_nxt = r_down + 24'd1;
            end
         end
         S_FAIL:  w_nxt = S_FAIL;
         default: w_nxt = S_OFF;
      endcase

      if (w_retry) begin
         if (retry_cnt == c_MAX_RETRY) begin
            w_nxt = S_FAIL;
         end else begin
            w_nxt       = S_PERST;
            w_retry_nxt = retry_cnt + 2'd1;
         end
      end

      if (w_nxt == S_UP && r_state != S_UP)
         w_retry_nxt = '0;

      if (w_abort) begin
         w_nxt       = S_OFF;
         w_retry_nxt = '0;
         w_down_nxt  = '0;
      end

      w_cnt_nxt = (w_nxt != r_state) ? 24'd0 : r_cnt + 24'd1;
   end

   // Outputs are decoded from the next state so they line up with r_state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_OFF;
         r_cnt      <= '0;
         r_down     <= '0;
         r_ltssm_q1 <= '0;
         r_ltssm_q  <= '0;
         w_dis_n    <= 2'b00;
         perst_n    <= 1'b0;
         npor       <= 1'b0;
         link_up    <= 1'b0;
         link_fail  <= 1'b0;
         retry_cnt  <= '0;
      end else begin
         r_ltssm_q1 <= ltssm;
         r_ltssm_q  <= r_ltssm_q1;
         r_state    <= w_nxt;
         r_cnt      <= w_cnt_nxt;
         r_down     <= w_down_nxt;
         retry_cnt  <= w_retry_nxt;
         w_dis_n    <= (w_nxt == S_PWR || w_nxt == S_PERST ||
                        w_nxt == S_TRAIN || w_nxt == S_UP) ? 2'b11 : 2'b00;
         perst_n    <= (w_nxt == S_TRAIN || w_nxt == S_UP);
         npor       <= (w_nxt == S_TRAIN || w_nxt == S_UP);
         link_up    <= (w_nxt == S_UP);
         link_fail  <= (w_nxt == S_FAIL);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pcie_rp_link_seq.sv
// tb_pcie_rp_link_seq: directed bench with a phase-level reference model for pcie_rp_link_seq.
// Revision 1.0
`default_nettype none

module tb_pcie_rp_link_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hps_ready = 1'b1;
   logic       sw_reset = 1'b0;
   logic       refclk_locked = 1'b1;
   logic [4:0] ltssm = 5'h00;
   logic [1:0] w_dis_n;
   logic       perst_n;
   logic       npor;
   logic       link_up;
   logic       link_fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   pcie_rp_link_seq dut (
      .clk           (clk),
      .reset         (reset),
      .hps_ready     (hps_ready),
      .sw_reset      (sw_reset),
      .refclk_locked (refclk_locked),
      .ltssm         (ltssm),
      .w_dis_n       (w_dis_n),
      .perst_n       (perst_n),
      .npor          (npor),
      .link_up       (link_up),
      .link_fail     (link_fail),
      .retry_cnt     (retry_cnt),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phases with remaining-cycle budgets and a 2-deep ltssm delay line
   int         m_st = 0;
   int         m_left = 0;
   int         m_retry = 0;
   int         m_down = 0;
   logic [4:0] m_p1 = 5'h00;
   logic [4:0] m_p2 = 5'h00;
   bit         m_l0;

   task automatic m_do_retry();
      if (m_retry == 3) begin
         m_st = 5;
      end else begin
         m_retry = m_retry + 1;
         m_st    = 2;
         m_left  = 32;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_st = 0; m_left = 0; m_retry = 0; m_down = 0;
         m_p1 = 5'h00; m_p2 = 5'h00;
      end else begin
         m_l0 = (m_p2 == 5'h0F);
         m_p2 = m_p1;
         m_p1 = ltssm;
         if (sw_reset || !hps_ready || !refclk_locked) begin
            m_st = 0;
            m_retry = 0;
         end else begin
            case (m_st)
               0: begin m_st = 1; m_left = 16; end
               1: begin m_left--; if (m_left == 0) begin m_st = 2; m_left = 32; end end
               2: begin m_left--; if (m_left == 0) begin m_st = 3; m_left = 1024; end end
               3: begin
                  m_left--;
                  if (m_l0) begin m_st = 4; m_retry = 0; m_down = 0; end
                  else if (m_left == 0) m_do_retry();
               end
               4: begin
                  m_down = m_l0 ? 0 : m_down + 1;
                  if (m_down == 4) m_do_retry();
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [10:0] m_expect();
      logic [1:0] wd;
      logic       on;
      wd = (m_st >= 1 && m_st <= 4) ? 2'b11 : 2'b00;
      on = (m_st == 3 || m_st == 4);
      return {3'(m_st), wd, on, on, (m_st == 4), (m_st == 5), 2'(m_retry)};
   endfunction

   always @(negedge clk) begin
      chk("cycle outputs", 32'({state, w_dis_n, perst_n, npor, link_up, link_fail, retry_cnt}),
          32'(m_expect()));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int rc_prev;
      int rc_steps;

      repeat (3) @(negedge clk);
      chk("reset state", 32'(state), 0);
      chk("reset w_dis_n", 32'(w_dis_n), 0);
      chk("reset perst_n", 32'(perst_n), 0);
      chk("reset link_fail", 32'(link_fail), 0);
      chk("reset retry_cnt", 32'(retry_cnt), 0);

      // Bring-up with L0 presented at cycle 60
      reset = 1'b0;
      k = 0;
      while (k < 200 && perst_n !== 1'b1) begin @(negedge clk); k++; end
      chk("perst_n rise cycle", 32'(k), 49);
      chk("state after perst rise", 32'(state), 3);
      while (k < 60) begin @(negedge clk); k++; end
      ltssm = 5'h0F;
      k = 0;
      while (k < 20 && link_up !== 1'b1) begin @(negedge clk); k++; end
      chk("link_up latency", 32'(k), 3);

      // Short glitch tolerated, long one is link loss
      ltssm = 5'h00;
      repeat (3) @(negedge clk);
      ltssm = 5'h0F;
      repeat (6) @(negedge clk);
      chk("glitch stays UP", 32'(state), 4);
      ltssm = 5'h00;
      repeat (8) @(negedge clk);
      chk("loss state", 32'(state), 2);
      chk("loss retry_cnt", 32'(retry_cnt), 1);
      chk("loss link_up", 32'(link_up), 0);

      // Abort during TRAIN with two retries used
      k = 0;
      while (k < 3000 && !(state == 3'd3 && retry_cnt == 2'd2)) begin @(negedge clk); k++; end
      chk("reach TRAIN retry2", 32'(k < 3000), 1);
      sw_reset = 1'b1;
      @(negedge clk);
      sw_reset = 1'b0;
      chk("abort state", 32'(state), 0);
      chk("abort retry_cnt", 32'(retry_cnt), 0);
      k = 0;
      while (k < 200 && perst_n !== 1'b1) begin @(negedge clk); k++; end
      chk("restart perst_n rise", 32'(k), 49);

      // Training timeout all the way to FAIL
      k = 0; rc_prev = 0; rc_steps = 0;
      while (k < 6000 && state !== 3'd5) begin
         @(negedge clk); k++;
         if (int'(retry_cnt) != rc_prev) begin
            if (int'(retry_cnt) == rc_prev + 1) rc_steps++;
            rc_prev = int'(retry_cnt);
         end
      end
      chk("cycles to FAIL", 32'(k), 4192);
      chk("retry steps", 32'(rc_steps), 3);
      chk("fail link_fail", 32'(link_fail), 1);
      chk("fail perst_n", 32'(perst_n), 0);
      chk("fail retry_cnt", 32'(retry_cnt), 3);
      repeat (5) @(negedge clk);
      chk("fail holds", 32'(state), 5);

      // L0 first seen exactly on the last TRAIN cycle
      sw_reset = 1'b1;
      @(negedge clk);
      sw_reset = 1'b0;
      k = 0;
      while (k < 200 && state !== 3'd3) begin @(negedge clk); k++; end
      repeat (1021) @(negedge clk);
      ltssm = 5'h0F;
      repeat (2) @(negedge clk);
      chk("boundary still TRAIN", 32'(state), 3);
      @(negedge clk);
      chk("boundary UP", 32'(state), 4);
      chk("boundary retry_cnt", 32'(retry_cnt), 0);

      // refclk loss in UP
      refclk_locked = 1'b0;
      @(negedge clk);
      chk("refclk drop state", 32'(state), 0);
      refclk_locked = 1'b1;

      // Asynchronous reset in PERST
      k = 0;
      while (k < 200 && state !== 3'd2) begin @(negedge clk); k++; end
      repeat (3) @(negedge clk);
      chk("pre-reset w_dis_n", 32'(w_dis_n), 3);
      #2 reset = 1'b1;
      #1;
      chk("async reset state", 32'(state), 0);
      chk("async reset w_dis_n", 32'(w_dis_n), 0);
      chk("async reset npor", 32'(npor), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
